// File: rtl/matmul_job_sequencer.sv
// rtl/matmul_job_sequencer.sv - shadow-table job sequencer feeding a 3x3 matmul coprocessor over PCPI
module matmul_job_sequencer #(
    parameter int NUM_WORDS = 28,
    parameter int SETTLE    = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        cfg_err,
    input  logic        job_start,
    input  logic        full_reload,
    output logic        busy,
    output logic        job_done,
    output logic        job_timeout,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_ready,
    input  logic        pcpi_wait
);
    localparam int AW = 5;
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [2:0] F3_LOAD    = 3'b000;
    localparam logic [2:0] F3_COMPUTE = 3'b111;
    localparam logic [2:0] F3_STOP    = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_STOP, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   flag_q, flag_d;
    logic [NUM_WORDS-1:0]   dirty_q, dirty_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [15:0]            shadow_q [NUM_WORDS];

    logic cfg_ok;
    logic last_idx;
    logic wait_done;
    logic wait_expired;

    function automatic logic [31:0] make_insn(input logic [2:0] f3, input logic [4:0] addr,
                                              input logic [15:0] value);
        return {1'b0, value, f3, addr, 7'b0001011};
    endfunction

    assign cfg_ok       = cfg_wr && (state_q == S_IDLE) && (cfg_addr < AW'(NUM_WORDS));
    assign last_idx     = (idx_q == AW'(NUM_WORDS - 1));
    assign wait_done    = (cnt_q >= CW'(SETTLE)) && pcpi_ready && !pcpi_wait;
    assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            dirty_q   <= '1;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            dirty_q   <= dirty_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Shadow contents survive reset so a reset only forces a full reload.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            shadow_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (job_start) state_d = S_LOAD;
            S_LOAD:  if (last_idx) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (wait_done || wait_expired) state_d = S_STOP;
            S_STOP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d     = '0;
        cnt_d     = '0;
        flag_d    = flag_q;
        dirty_d   = dirty_q;
        cfg_err_d = cfg_wr && !cfg_ok;
        // A write accepted alongside job_start is already dirty for that job.
        if (cfg_ok) begin
            dirty_d[cfg_addr] = 1'b1;
        end
        if (state_q == S_IDLE && job_start && full_reload) begin
            dirty_d = '1;
        end
        if (state_q == S_LOAD) begin
            dirty_d[idx_q] = 1'b0;
            if (!last_idx) begin
                idx_d = idx_q + AW'(1);
            end
        end
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q + CW'(1);
            if (wait_done || wait_expired) begin
                flag_d = !wait_done;
            end
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        job_done    = (state_q == S_DONE);
        job_timeout = (state_q == S_DONE) && flag_q;
        cfg_err     = cfg_err_q;
        pcpi_valid  = 1'b0;
        pcpi_insn   = '0;
        case (state_q)
            S_LOAD: begin
                if (dirty_q[idx_q]) begin
                    pcpi_valid = 1'b1;
                    pcpi_insn  = make_insn(F3_LOAD, idx_q, shadow_q[idx_q]);
                end
            end
            S_START: begin
                pcpi_valid = 1'b1;
                pcpi_insn  = make_insn(F3_COMPUTE, 5'd0, 16'd0);
            end
            S_STOP: begin
                pcpi_valid = 1'b1;
                pcpi_insn  = make_insn(F3_STOP, 5'd0, 16'd0);
            end
            default: ;
        endcase
    end
endmodule
